// File: rtl/relu_backward_ctrl.sv
// Purpose: sequences one relu_backward_opt job: stream LEN source words through the datapath into the destination buffer.
// Latency: write i lands MEM_RD_LAT+1+RELU_LAT cycles after read i; done at LEN+MEM_RD_LAT+RELU_LAT+2 after accepted start.
// Backpressure: none; one read per cycle with no gaps, memories and datapath must accept every strobe.
//
// Ports:
//   clk, reset            clock (posedge) and synchronous active-high reset
//   start/len/src_base/dst_base
//                         job request; sampled only while idle
//   busy, done            busy from the cycle after acceptance through the done cycle; done is a 1-cycle pulse
//   rd_en/rd_addr/rd_data source buffer read port (synchronous-read RAM)
//   relu_in/relu_out      to/from the external relu_backward_opt instance
//   wr_en/wr_addr/wr_data destination buffer write port
//   pos_count             number of strictly positive inputs in the last/current job
module relu_backward_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_RD_LAT = 1,
  parameter int RELU_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] relu_in,
  input  logic [DATA_WIDTH-1:0] relu_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   pos_count
);

  // Read strobe -> data valid (MEM_RD_LAT) -> relu_in register (1) -> datapath (RELU_LAT) -> write.
  localparam int PIPE_DEPTH = MEM_RD_LAT + 1 + RELU_LAT;
  localparam int CNT_W      = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Job parameters captured at acceptance; later start/len/base changes are ignored.
  logic [CNT_W-1:0]      len_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;

  // Counts of reads issued and writes issued in the current job. They are one bit
  // wider than an address so that LEN = 2^ADDR_WIDTH is representable.
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;

  // Bit k set means a read was issued k+1 cycles ago.
  logic [PIPE_DEPTH-1:0] vld_pipe_q;

  logic start_acc;
  logic rd_vld;
  logic last_rd;
  logic last_wr;
  logic in_pos;
  logic [CNT_W-1:0] len_m1;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign len_m1    = len_q - CNT_W'(1);

  assign rd_en   = (state_q == ST_ISSUE);
  assign rd_vld  = vld_pipe_q[MEM_RD_LAT-1];
  assign wr_en   = vld_pipe_q[PIPE_DEPTH-1];

  assign last_rd = rd_en && (rd_cnt_q == len_m1);
  assign last_wr = wr_en && (wr_cnt_q == len_m1);

  // Address arithmetic wraps modulo 2^ADDR_WIDTH by truncation.
  assign rd_addr = src_q + rd_cnt_q[ADDR_WIDTH-1:0];
  assign wr_addr = dst_q + wr_cnt_q[ADDR_WIDTH-1:0];
  assign wr_data = relu_out;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // Strictly positive: sign clear and not +0.0. Positive NaN/Inf count, matching
  // the datapath's own sign/zero test.
  assign in_pos = !rd_data[DATA_WIDTH-1] && (rd_data[DATA_WIDTH-2:0] != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero-length job skips straight to the done pulse with no memory traffic.
          state_d = (len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_wr) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Clearing the valid pipe drops any in-flight writes of an aborted job.
      state_q    <= ST_IDLE;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      vld_pipe_q <= '0;
      relu_in    <= '0;
      pos_count  <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= {vld_pipe_q[PIPE_DEPTH-2:0], rd_en};

      if (start_acc) begin
        len_q     <= len;
        src_q     <= src_base;
        dst_q     <= dst_base;
        rd_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        pos_count <= '0;
      end else begin
        if (rd_en)  rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        if (wr_en)  wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (rd_vld && in_pos) pos_count <= pos_count + CNT_W'(1);
      end

      // relu_in holds its last value between loads.
      if (rd_vld) relu_in <= rd_data;
    end
  end

endmodule

// File: tb/tb_relu_backward_ctrl.sv
module tb_relu_backward_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [31:0] NEG_SLOPE = 32'h38D1B717; // 1e-4

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, relu_in, relu_out, wr_data;
  logic [AW:0]   pos_count;

  logic [31:0] src_mem [0:1023];
  logic [31:0] dst_mem [0:1023];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  relu_backward_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .relu_in(relu_in), .relu_out(relu_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pos_count(pos_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_pos(input logic [31:0] x);
    return !x[31] && (x[30:0] != 31'd0);
  endfunction

  function automatic logic [31:0] grad(input logic [31:0] x);
    return is_pos(x) ? x : NEG_SLOPE;
  endfunction

  // Environment stand-ins: sync-read source RAM, 1-cycle datapath, destination RAM.
  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];
  always @(posedge clk) relu_out <= grad(relu_in);
  always @(posedge clk) if (wr_en) dst_mem[wr_addr] <= wr_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- job-level reference model ----------------
  bit           job_valid = 0;
  int           c0 = 0;
  int           jl = 0;
  int           done_k = 0;
  logic [9:0]   js = '0;
  logic [9:0]   jd = '0;
  logic [31:0]  exp_data [0:1023];
  int           exp_pos = 0;
  int           total_elems = 0;

  int rd_log[$];
  int rd_cyc_log[$];
  int wr_log[$];
  int wr_cyc_log[$];
  int done_log[$];

  function automatic bit model_idle();
    return !job_valid || ((cyc - c0) > done_k);
  endfunction

  initial begin : compare
    int k;
    bit e_busy, e_done, e_rd, e_wr;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      k      = cyc - c0;
      e_busy = job_valid && k >= 1 && k <= done_k;
      e_done = job_valid && k == done_k;
      e_rd   = job_valid && jl > 0 && k >= 1 && k <= jl;
      e_wr   = job_valid && jl > 0 && k >= 4 && k <= jl + 3;
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("rd_en", 64'(rd_en), 64'(e_rd));
      chk("wr_en", 64'(wr_en), 64'(e_wr));
      if (e_rd) chk("rd_addr", 64'(rd_addr), 64'(10'(js + 10'(k - 1))));
      if (e_wr) begin
        chk("wr_addr", 64'(wr_addr), 64'(10'(jd + 10'(k - 4))));
        chk("wr_data", 64'(wr_data), 64'(exp_data[k - 4]));
      end
      if (!job_valid || jl == 0 || k >= jl + 2) chk("pos_count", 64'(pos_count), 64'(exp_pos));

      if (rd_en === 1'b1) begin rd_log.push_back(int'(rd_addr)); rd_cyc_log.push_back(cyc); end
      if (wr_en === 1'b1) begin wr_log.push_back(int'(wr_addr)); wr_cyc_log.push_back(cyc); end
      if (done === 1'b1) done_log.push_back(cyc);

      // Inputs sampled at the coming edge shape the following cycles.
      if (reset) begin
        job_valid = 0;
        exp_pos   = 0;
      end else if (start && (!job_valid || k > done_k)) begin
        job_valid = 1;
        c0        = cyc;
        jl        = int'(len);
        js        = src_base;
        jd        = dst_base;
        done_k    = (jl == 0) ? 1 : jl + 4;
        exp_pos   = 0;
        for (int i = 0; i < jl; i++) begin
          x = src_mem[10'(js + 10'(i))];
          exp_data[i] = grad(x);
          if (is_pos(x)) exp_pos++;
        end
        total_elems += jl;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int l, input int s, input int d, output int lc);
    start = 1'b1; len = 11'(l); src_base = 10'(s); dst_base = 10'(d);
    lc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b;
    bit seen;
    b = done_log.size();
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_log.size() > b) seen = 1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] rand_float();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'h7FC0_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    int lc, b_rd, b_wr, b_dn, nd, rand_start, guard;
    bit seen_a [0:1023];
    for (int i = 0; i < 1024; i++) begin src_mem[i] = '0; dst_mem[i] = '0; end

    // 1: reset then idle
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rd_addr", 64'(rd_addr), 64'd0);
    chk("idle_wr_addr", 64'(wr_addr), 64'd0);
    chk("idle_relu_in", 64'(relu_in), 64'd0);
    chk("idle_pos_count", 64'(pos_count), 64'd0);

    // 2: basic job with literal expectations
    src_mem[0] = 32'h3F80_0000; src_mem[1] = 32'hC000_0000;
    src_mem[2] = 32'h0000_0000; src_mem[3] = 32'h4060_0000;
    b_rd = rd_cyc_log.size(); b_wr = wr_cyc_log.size(); b_dn = done_log.size();
    go(4, 0, 16, lc);
    wait_done(40);
    chk("t2_dst16", 64'(dst_mem[16]), 64'h3F80_0000);
    chk("t2_dst17", 64'(dst_mem[17]), 64'(NEG_SLOPE));
    chk("t2_dst18", 64'(dst_mem[18]), 64'(NEG_SLOPE));
    chk("t2_dst19", 64'(dst_mem[19]), 64'h4060_0000);
    chk("t2_pos_count", 64'(pos_count), 64'd2);
    if (done_log.size() > b_dn) chk("t2_done_cycle", 64'(done_log[b_dn] - lc), 64'd8);
    if (wr_cyc_log.size() > b_wr && rd_cyc_log.size() > b_rd)
      chk("t2_rd_to_wr", 64'(wr_cyc_log[b_wr] - rd_cyc_log[b_rd]), 64'd3);

    // 3: zero-length job
    b_rd = rd_log.size(); b_wr = wr_log.size(); b_dn = done_log.size();
    go(0, 5, 5, lc);
    wait_done(10);
    if (done_log.size() > b_dn) chk("t3_done_cycle", 64'(done_log[b_dn] - lc), 64'd1);
    chk("t3_no_rd", 64'(rd_log.size() - b_rd), 64'd0);
    chk("t3_no_wr", 64'(wr_log.size() - b_wr), 64'd0);
    chk("t3_pos_count", 64'(pos_count), 64'd0);

    // 4: address wrap
    b_rd = rd_log.size(); b_wr = wr_log.size();
    go(3, 1022, 1023, lc);
    wait_done(40);
    chk("t4_rd_n", 64'(rd_log.size() - b_rd), 64'd3);
    chk("t4_wr_n", 64'(wr_log.size() - b_wr), 64'd3);
    if (rd_log.size() - b_rd == 3) begin
      chk("t4_rd0", 64'(rd_log[b_rd]), 64'd1022);
      chk("t4_rd1", 64'(rd_log[b_rd + 1]), 64'd1023);
      chk("t4_rd2", 64'(rd_log[b_rd + 2]), 64'd0);
    end
    if (wr_log.size() - b_wr == 3) begin
      chk("t4_wr0", 64'(wr_log[b_wr]), 64'd1023);
      chk("t4_wr1", 64'(wr_log[b_wr + 1]), 64'd0);
      chk("t4_wr2", 64'(wr_log[b_wr + 2]), 64'd1);
    end

    // 5: restart attempt mid-job is ignored
    b_wr = wr_log.size(); b_dn = done_log.size();
    go(4, 100, 200, lc);
    tick();
    start = 1'b1; len = 11'd7; src_base = 10'd300; dst_base = 10'd400;
    tick();
    start = 1'b0;
    wait_done(40);
    repeat (10) tick();
    chk("t5_wr_n", 64'(wr_log.size() - b_wr), 64'd4);
    chk("t5_done_n", 64'(done_log.size() - b_dn), 64'd1);

    // 5b: start held over the done cycle is taken one cycle later
    b_wr = wr_log.size(); b_dn = done_log.size();
    go(2, 10, 500, lc);
    nd = 0;
    for (int i = 0; i < 40 && nd == 0; i++) begin tick(); if (done) nd = 1; end
    chk("t5b_saw_done", 64'(nd), 64'd1);
    start = 1'b1; len = 11'd5; src_base = 10'd20; dst_base = 10'd600;
    tick();
    lc = cyc;
    tick();
    start = 1'b0;
    wait_done(40);
    chk("t5b_wr_n", 64'(wr_log.size() - b_wr), 64'd7);
    if (done_log.size() > b_dn + 1) chk("t5b_done_cycle", 64'(done_log[b_dn + 1] - lc), 64'd9);

    // 6: reset mid-job, then a clean job
    go(8, 0, 50, lc);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_rd = rd_log.size(); b_wr = wr_log.size(); b_dn = done_log.size();
    repeat (20) tick();
    chk("t6_no_rd", 64'(rd_log.size() - b_rd), 64'd0);
    chk("t6_no_wr", 64'(wr_log.size() - b_wr), 64'd0);
    chk("t6_no_done", 64'(done_log.size() - b_dn), 64'd0);
    chk("t6_pos_cleared", 64'(pos_count), 64'd0);
    go(6, 0, 60, lc);
    wait_done(40);
    chk("t6_wr_after", 64'(wr_log.size() - b_wr), 64'd6);

    // Full-length job: every address touched exactly once
    for (int i = 0; i < 1024; i++) src_mem[i] = rand_float();
    b_wr = wr_log.size();
    go(1024, 700, 300, lc);
    wait_done(1100);
    for (int i = 0; i < 1024; i++) seen_a[i] = 0;
    nd = 0;
    for (int i = b_wr; i < wr_log.size(); i++) begin
      if (!seen_a[wr_log[i]]) nd++;
      seen_a[wr_log[i]] = 1;
    end
    chk("full_wr_distinct", 64'(nd), 64'd1024);
    chk("full_wr_n", 64'(wr_log.size() - b_wr), 64'd1024);

    // Random traffic: random start patterns, lengths and bases, checked every cycle
    rand_start = total_elems;
    guard = 0;
    while (total_elems - rand_start < 10000 && guard < 200) begin
      guard++;
      for (int i = 0; i < 1024; i++) src_mem[i] = rand_float();
      repeat (400) begin
        start = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 19))
          0: len = 11'd0;
          1: len = 11'($urandom_range(200, 1024));
          default: len = 11'($urandom_range(1, 64));
        endcase
        src_base = 10'($urandom);
        dst_base = 10'($urandom);
        tick();
      end
      start = 1'b0;
      nd = 0;
      for (int i = 0; i < 1200 && nd == 0; i++) begin
        tick();
        if (model_idle() && !busy) nd = 1;
      end
      if (nd == 0) chk("rand_idle_timeout", 64'd0, 64'd1);
    end
    chk("rand_volume", 64'(total_elems - rand_start >= 10000), 64'd1);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
